// File: rtl/wb_serial_initiator_pkg.sv
// rtl/wb_serial_initiator_pkg.sv - shared types and UART register map for the Wishbone serial initiator
//
// Purpose: FSM state encoding, NS16550-style register offsets and the THR-empty
// status bit position used when polling the UART interrupt status register.
// Ports: none (package).

package wb_serial_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_POLL       = 2'd1,
        ST_POLL_WAIT  = 2'd2,
        ST_WRITE_WAIT = 2'd3
    } state_t;

    // UART register offsets relative to the block base address.
    localparam logic [7:0] REG_USART_THR = 8'h00;
    localparam logic [7:0] REG_USART_ISR = 8'h02;

    // ISR bit that reads 1 when the transmit holding register can take a byte.
    localparam int ISR_THRE_BIT = 1;

    // Bits needed to hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// rtl/sync_byte_fifo.sv - single-clock byte FIFO with first-word-fall-through head
//
// Purpose: buffers bytes between the producer and the bus FSM.
// Ports:
//   clk    in   clock, rising edge
//   resetn in   synchronous active-low reset, empties the FIFO
//   push   in   write din (ignored when full)
//   din    in   byte to write
//   pop    in   discard the head entry (ignored when empty)
//   head   out  oldest stored byte, valid while empty=0
//   full   out  DEPTH entries stored
//   empty  out  no entries stored

module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_serial_initiator.sv
// rtl/wb_serial_initiator.sv - Wishbone initiator draining a byte stream into an NS16550-style UART
//
// Purpose: each buffered byte is sent by polling ISR until THR-empty is set,
// then writing the byte to THR with a single-beat Wishbone write.
// Ports:
//   wb_clk_i    in   clock, rising edge
//   wb_reset_i  in   synchronous active-low reset
//   tx_data     in   byte to send
//   tx_valid    in   tx_data valid
//   tx_ready    out  FIFO not full; byte taken when tx_valid && tx_ready
//   wb_adr_o    out  Wishbone address
//   wb_dat_o    out  write data, byte in [7:0]
//   wb_dat_i    in   read data (ISR)
//   wb_we_o     out  1 = THR write, 0 = ISR read
//   wb_sel_o    out  byte select, lane 0 only
//   wb_cyc_o    out  bus cycle
//   wb_stb_o    out  strobe
//   wb_ack_i    in   slave acknowledge
//   busy        out  FSM active or bytes pending
//   sent_pulse  out  one-cycle pulse per acknowledged THR write
//   err_sticky  out  ack timeout or poll-limit drop seen since reset

module wb_serial_initiator
    import wb_serial_initiator_pkg::*;
#(
    parameter int            AW          = 32,
    parameter int            DW          = 32,
    parameter logic [AW-1:0] BASE_ADDR   = '0,
    parameter int            FIFO_DEPTH  = 16,
    parameter int            POLL_LIMIT  = 255,
    parameter int            ACK_TIMEOUT = 64
) (
    input  logic            wb_clk_i,
    input  logic            wb_reset_i,
    input  logic [7:0]      tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            wb_we_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic            wb_ack_i,
    output logic            busy,
    output logic            sent_pulse,
    output logic            err_sticky
);

    localparam int PCW = cnt_width(POLL_LIMIT);
    localparam int WCW = cnt_width(ACK_TIMEOUT);

    state_t          state, state_n;
    logic            cyc_q, cyc_n;
    logic            we_q, we_n;
    logic [AW-1:0]   adr_q, adr_n;
    logic [DW-1:0]   dat_q, dat_n;
    logic            sent_q, sent_n;
    logic            err_q, err_n;
    logic [PCW-1:0]  poll_cnt, poll_n;
    logic [WCW-1:0]  wait_cnt, wait_n;

    logic            fifo_push;
    logic            fifo_pop;
    logic [7:0]      fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            ack;
    logic            timeout;
    logic            unused_dat;

    assign fifo_push = tx_valid && !fifo_full;

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (wb_clk_i),
        .resetn (wb_reset_i),
        .push   (fifo_push),
        .din    (tx_data),
        .pop    (fifo_pop),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Only the THR-empty bit of ISR matters.
    assign unused_dat = ^{wb_dat_i[DW-1:ISR_THRE_BIT+1], wb_dat_i[ISR_THRE_BIT-1:0]};

    // A stray ack outside a cycle must not advance the FSM.
    assign ack     = wb_ack_i && cyc_q;
    assign timeout = cyc_q && !wb_ack_i && (wait_cnt == WCW'(ACK_TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_i) begin
            state    <= ST_IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sent_q   <= 1'b0;
            err_q    <= 1'b0;
            poll_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            cyc_q    <= cyc_n;
            we_q     <= we_n;
            adr_q    <= adr_n;
            dat_q    <= dat_n;
            sent_q   <= sent_n;
            err_q    <= err_n;
            poll_cnt <= poll_n;
            wait_cnt <= wait_n;
        end
    end

    always_comb begin
        state_n  = state;
        cyc_n    = cyc_q;
        we_n     = we_q;
        adr_n    = adr_q;
        dat_n    = dat_q;
        sent_n   = 1'b0;
        err_n    = err_q;
        poll_n   = poll_cnt;
        wait_n   = wait_cnt;
        fifo_pop = 1'b0;

        case (state)
            ST_IDLE: begin
                cyc_n = 1'b0;
                we_n  = 1'b0;
                if (!fifo_empty) begin
                    state_n = ST_POLL;
                end
            end

            ST_POLL: begin
                cyc_n   = 1'b1;
                we_n    = 1'b0;
                adr_n   = BASE_ADDR + AW'(REG_USART_ISR);
                dat_n   = '0;
                wait_n  = '0;
                state_n = ST_POLL_WAIT;
            end

            ST_POLL_WAIT: begin
                if (ack) begin
                    cyc_n = 1'b0;
                    if (wb_dat_i[ISR_THRE_BIT]) begin
                        poll_n  = '0;
                        state_n = ST_WRITE_WAIT;
                    end else if (poll_cnt == PCW'(POLL_LIMIT - 1)) begin
                        poll_n   = '0;
                        fifo_pop = 1'b1;
                        err_n    = 1'b1;
                        state_n  = ST_IDLE;
                    end else begin
                        poll_n  = poll_cnt + PCW'(1);
                        state_n = ST_POLL;
                    end
                end else if (timeout) begin
                    cyc_n    = 1'b0;
                    err_n    = 1'b1;
                    fifo_pop = 1'b1;
                    poll_n   = '0;
                    state_n  = ST_IDLE;
                end else begin
                    wait_n = wait_cnt + WCW'(1);
                end
            end

            ST_WRITE_WAIT: begin
                // Entered with cyc low so the ISR read and THR write are
                // separated by one idle cycle; the write is issued here.
                if (!cyc_q) begin
                    cyc_n  = 1'b1;
                    we_n   = 1'b1;
                    adr_n  = BASE_ADDR + AW'(REG_USART_THR);
                    dat_n  = DW'(fifo_head);
                    wait_n = '0;
                end else if (ack) begin
                    cyc_n    = 1'b0;
                    we_n     = 1'b0;
                    dat_n    = '0;
                    fifo_pop = 1'b1;
                    sent_n   = 1'b1;
                    state_n  = ST_IDLE;
                end else if (timeout) begin
                    cyc_n    = 1'b0;
                    we_n     = 1'b0;
                    dat_n    = '0;
                    err_n    = 1'b1;
                    fifo_pop = 1'b1;
                    poll_n   = '0;
                    state_n  = ST_IDLE;
                end else begin
                    wait_n = wait_cnt + WCW'(1);
                end
            end

            default: begin
                cyc_n   = 1'b0;
                we_n    = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    assign tx_ready   = !fifo_full;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_we_o    = we_q;
    assign wb_sel_o   = (DW/8)'(1);
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign busy       = (state != ST_IDLE) || !fifo_empty;
    assign sent_pulse = sent_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_wb_serial_initiator.sv
// tb/tb_wb_serial_initiator.sv - scoreboard bench for wb_serial_initiator against a UART slave model

module tb_wb_serial_initiator;

    localparam logic [31:0] BASE    = 32'h1000_0000;
    localparam logic [31:0] ISR_ADR = 32'h1000_0002;
    localparam logic [31:0] THR_ADR = 32'h1000_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_reset_i = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        busy;
    logic        sent_pulse;
    logic        err_sticky;

    wb_serial_initiator #(
        .AW          (32),
        .DW          (32),
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (16),
        .POLL_LIMIT  (4),
        .ACK_TIMEOUT (8)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_reset_i (wb_reset_i),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_ack_i   (wb_ack_i),
        .busy       (busy),
        .sent_pulse (sent_pulse),
        .err_sticky (err_sticky)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // UART slave model: ack after ack_delay cycles of strobe; ISR reads 0
    // while stuck or until isr_zero_until reads have been served, else 2.
    int  ack_delay = 0;
    bit  never_ack = 1'b0;
    bit  isr_stuck = 1'b0;
    int  isr_zero_until = 0;
    int  slave_cnt = 0;
    int  isr_reads = 0;

    assign wb_ack_i = wb_cyc_o && wb_stb_o && !never_ack && (slave_cnt >= ack_delay);
    assign wb_dat_i = (isr_stuck || (isr_reads < isr_zero_until)) ? 32'h0 : 32'h2;

    always @(posedge wb_clk_i) begin
        slave_cnt <= (wb_cyc_o && wb_stb_o) ? slave_cnt + 1 : 0;
        if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_we_o) begin
            isr_reads <= isr_reads + 1;
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_fail = 0;
    int  sent_cnt = 0;

    task automatic exp_isr();
        ev_t e;
        e.we = 1'b0; e.adr = ISR_ADR; e.dat = 32'h0;
        exp_q.push_back(e);
    endtask

    task automatic exp_thr(input logic [7:0] b);
        ev_t e;
        e.we = 1'b1; e.adr = THR_ADR; e.dat = {24'h0, b};
        exp_q.push_back(e);
    endtask

    // Monitor: every acknowledged bus beat is popped from the scoreboard.
    initial begin
        forever begin
            @(negedge wb_clk_i);
            if (sent_pulse === 1'b1) begin
                sent_cnt++;
            end
            if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1 && wb_ack_i === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_unexpected: got we=%0b adr=%h dat=%h, required no transaction",
                             wb_we_o, wb_adr_o, wb_dat_o);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (wb_we_o !== e.we || wb_adr_o !== e.adr || wb_sel_o !== 4'b0001 ||
                        (e.we && wb_dat_o !== e.dat)) begin
                        n_fail++;
                        $display("FAIL bus_beat: got we=%0b adr=%h dat=%h sel=%b, required we=%0b adr=%h dat=%h sel=0001",
                                 wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, e.we, e.adr, e.dat);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send(input logic [7:0] b);
        int g;
        g = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && g < 1000) begin
            @(negedge wb_clk_i);
            g++;
        end
        if (g >= 1000) begin
            check("send_ready_timeout", 32'(tx_ready), 32'h1);
        end
        @(negedge wb_clk_i);
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        @(negedge wb_clk_i);
        while ((busy || exp_q.size() != 0) && g < 3000) begin
            @(negedge wb_clk_i);
            g++;
        end
        check(name, 32'(busy), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge wb_clk_i);
        tx_valid   = 1'b0;
        wb_reset_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        wb_reset_i = 1'b1;
    endtask

    initial begin
        int s0;
        int hi;
        int g;

        // Reset state
        repeat (3) @(negedge wb_clk_i);
        check("rst_cyc", 32'(wb_cyc_o), 32'h0);
        check("rst_stb", 32'(wb_stb_o), 32'h0);
        check("rst_we", 32'(wb_we_o), 32'h0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_tx_ready", 32'(tx_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_sent", 32'(sent_pulse), 32'h0);
        check("rst_err", 32'(err_sticky), 32'h0);
        wb_reset_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);

        // Latency with 1-cycle-ack slave: push at edge N
        exp_isr();
        exp_thr(8'h48);
        tx_data  = 8'h48;
        tx_valid = 1'b1;
        @(negedge wb_clk_i);
        tx_valid = 1'b0;
        @(negedge wb_clk_i);
        check("lat_n1_stb", 32'(wb_stb_o), 32'h0);
        @(negedge wb_clk_i);
        check("lat_n2_stb", 32'(wb_stb_o), 32'h1);
        check("lat_n2_we", 32'(wb_we_o), 32'h0);
        check("lat_n2_adr", wb_adr_o, ISR_ADR);
        @(negedge wb_clk_i);
        check("lat_n3_stb", 32'(wb_stb_o), 32'h0);
        @(negedge wb_clk_i);
        check("lat_n4_stb", 32'(wb_stb_o), 32'h1);
        check("lat_n4_we", 32'(wb_we_o), 32'h1);
        check("lat_n4_dat", wb_dat_o, 32'h48);
        @(negedge wb_clk_i);
        check("lat_n5_sent", 32'(sent_pulse), 32'h1);
        check("lat_n5_stb", 32'(wb_stb_o), 32'h0);
        exp_isr();
        exp_thr(8'h69);
        send(8'h69);
        tx_valid = 1'b0;
        wait_idle("hi_idle");
        check("hi_sent_cnt", 32'(sent_cnt), 32'd2);
        check("hi_err", 32'(err_sticky), 32'h0);

        // 20 bytes back-to-back against a slow slave: FIFO fills at 16
        ack_delay = 6;
        s0 = sent_cnt;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            b = 8'h60 + 8'(i);
            exp_isr();
            exp_thr(b);
            send(b);
            if (i == 14) check("fill_15_ready", 32'(tx_ready), 32'h1);
            if (i == 15) check("fill_16_ready", 32'(tx_ready), 32'h0);
        end
        tx_valid = 1'b0;
        wait_idle("fill_idle");
        check("fill_sent_cnt", 32'(sent_cnt - s0), 32'd20);
        ack_delay = 0;

        // ISR reads 0 three times, then THR empty
        isr_zero_until = isr_reads + 3;
        repeat (4) exp_isr();
        exp_thr(8'hA5);
        s0 = sent_cnt;
        send(8'hA5);
        tx_valid = 1'b0;
        wait_idle("poll3_idle");
        check("poll3_sent", 32'(sent_cnt - s0), 32'd1);
        check("poll3_err", 32'(err_sticky), 32'h0);

        // ISR stuck at 0: four polls then drop; next byte still delivered
        isr_stuck = 1'b1;
        repeat (4) exp_isr();
        s0 = sent_cnt;
        send(8'h77);
        tx_valid = 1'b0;
        wait_idle("drop_idle");
        check("drop_err", 32'(err_sticky), 32'h1);
        check("drop_sent", 32'(sent_cnt - s0), 32'd0);
        isr_stuck = 1'b0;
        exp_isr();
        exp_thr(8'h31);
        send(8'h31);
        tx_valid = 1'b0;
        wait_idle("after_drop_idle");
        check("after_drop_sent", 32'(sent_cnt - s0), 32'd1);

        do_reset();
        @(negedge wb_clk_i);
        check("rst2_err", 32'(err_sticky), 32'h0);
        check("rst2_tx_ready", 32'(tx_ready), 32'h1);

        // Slave never acks: cycle aborted after 8 wait cycles
        never_ack = 1'b1;
        send(8'h55);
        tx_valid = 1'b0;
        g = 0;
        while (!wb_stb_o && g < 50) begin
            @(negedge wb_clk_i);
            g++;
        end
        hi = 0;
        while (wb_stb_o && hi < 100) begin
            hi++;
            @(negedge wb_clk_i);
        end
        check("to_stb_cycles", 32'(hi), 32'd8);
        check("to_cyc", 32'(wb_cyc_o), 32'h0);
        check("to_err", 32'(err_sticky), 32'h1);
        check("to_busy", 32'(busy), 32'h0);
        never_ack = 1'b0;

        do_reset();

        // Reset while a THR write is outstanding
        ack_delay = 3;
        exp_isr();
        s0 = sent_cnt;
        send(8'h99);
        tx_valid = 1'b0;
        g = 0;
        while (!(wb_stb_o && wb_we_o) && g < 100) begin
            @(negedge wb_clk_i);
            g++;
        end
        check("mid_write_seen", 32'(wb_we_o), 32'h1);
        wb_reset_i = 1'b0;
        @(negedge wb_clk_i);
        check("mid_rst_cyc", 32'(wb_cyc_o), 32'h0);
        check("mid_rst_stb", 32'(wb_stb_o), 32'h0);
        check("mid_rst_we", 32'(wb_we_o), 32'h0);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'h1);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_err", 32'(err_sticky), 32'h0);
        wb_reset_i = 1'b1;
        ack_delay  = 0;
        repeat (10) @(negedge wb_clk_i);
        check("mid_rst_no_send", 32'(sent_cnt - s0), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
